// File: rtl/treeval_mx.sv
// Tree evaluator: one backward sweep over a stored tree (one node per cycle) to get the root value and action.
// Optional TREEVAL_SAT_EN: saturate contribution narrowing and EXP accumulation instead of wrapping.
module treeval_mx #(
    parameter int MAX_NODES = 16,
    parameter int W_ADDR    = 10,
    parameter int W_N_DATA  = 10,
    parameter int W_C_DATA  = 10,
    parameter int W_REWARD  = 10,
    parameter int W_WEIGHT  = 10,
    parameter int W_FRAC    = 7,
    parameter int W_ACTION  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_weight,
    input  logic                mem_par,
    input  logic                mem_rew,
    input  logic                mem_act,
    input  logic [W_ADDR-1:0]   mem_addr,
    input  logic [W_N_DATA-1:0] mem_data,
    input  logic                conf_nodes,
    input  logic [W_C_DATA-1:0] conf_data,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                exp_change,
    output logic [W_REWARD-1:0] exp,
    output logic [W_ACTION-1:0] act
);
    localparam int IW = $clog2(MAX_NODES);
    localparam int NW = $clog2(MAX_NODES + 1);
    localparam int PW = W_REWARD + W_WEIGHT + 1;

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_FINAL, S_DONE} state_t;

    state_t state_q, state_d;

    logic        [W_ADDR-1:0]   parent_mem [MAX_NODES];
    logic signed [W_REWARD-1:0] reward_mem [MAX_NODES];
    logic        [W_WEIGHT-1:0] weight_mem [MAX_NODES];
    logic        [W_ACTION-1:0] action_mem [MAX_NODES];
    logic        [1:0]          strat_mem  [MAX_NODES];
    logic signed [W_REWARD-1:0] acc_mem    [MAX_NODES];
    logic signed [W_REWARD-1:0] bestc_mem  [MAX_NODES];
    logic        [IW-1:0]       best_mem   [MAX_NODES];

    logic [MAX_NODES-1:0] has_child_q, has_child_d;
    logic [W_ADDR-1:0]    idx_q, idx_d;
    logic [NW-1:0]        nodes_q, nodes_d;
    logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                 chg_q, chg_d, exp_change_q, exp_change_d;
    logic [W_REWARD-1:0]  exp_q, exp_d;
    logic [W_ACTION-1:0]  act_q, act_d;

    logic                       in_idle, wr_ok, bad, node_wr, best_take;
    logic [IW-1:0]              waddr, idx_i, p_i;
    logic [W_ADDR-1:0]          p_full;
    logic [NW-1:0]              conf_clamped, nodes_eff;
    logic signed [W_REWARD-1:0] v_val, c_val, acc_cur, bestc_cur, exp_sum, acc_new, bestc_new;
    logic signed [PW-1:0]       prod;

    localparam logic signed [W_REWARD-1:0] SMAX = {1'b0, {(W_REWARD-1){1'b1}}};
    localparam logic signed [W_REWARD-1:0] SMIN = {1'b1, {(W_REWARD-1){1'b0}}};

    assign in_idle = (state_q == S_IDLE);
    assign wr_ok   = in_idle && (mem_addr < W_ADDR'(MAX_NODES));
    assign waddr   = mem_addr[IW-1:0];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (mem_weight) weight_mem[waddr] <= mem_data[W_WEIGHT-1:0];
            if (mem_par)    parent_mem[waddr] <= mem_data[W_ADDR-1:0];
            if (mem_rew)    reward_mem[waddr] <= mem_data[W_REWARD-1:0];
            if (mem_act) begin
                action_mem[waddr] <= mem_data[W_ACTION-1:0];
                strat_mem[waddr]  <= mem_data[W_ACTION+1:W_ACTION];
            end
        end
    end

    always_comb begin
        if (conf_data == '0)
            conf_clamped = NW'(1);
        else if (conf_data > W_C_DATA'(MAX_NODES))
            conf_clamped = NW'(MAX_NODES);
        else
            conf_clamped = conf_data[NW-1:0];
        nodes_eff = (in_idle && conf_nodes) ? conf_clamped : nodes_q;
    end

    // Contribution of the node being swept, scaled by its fixed-point weight.
    assign idx_i  = idx_q[IW-1:0];
    assign p_full = parent_mem[idx_i];
    assign p_i    = p_full[IW-1:0];
    assign bad    = (p_full >= idx_q);
    assign v_val  = has_child_q[idx_i] ? acc_mem[idx_i] : reward_mem[idx_i];
    assign prod   = $signed({{(W_WEIGHT+1){v_val[W_REWARD-1]}}, v_val})
                  * $signed({{(W_REWARD+1){1'b0}}, weight_mem[idx_i]});
    assign acc_cur   = acc_mem[p_i];
    assign bestc_cur = bestc_mem[p_i];

`ifdef TREEVAL_SAT_EN
    logic signed [PW-1:0]     shifted;
    logic signed [W_REWARD:0] sum_wide;
    always_comb begin
        shifted  = prod >>> W_FRAC;
        if ((&shifted[PW-1:W_REWARD-1]) || !(|shifted[PW-1:W_REWARD-1]))
            c_val = shifted[W_REWARD-1:0];
        else
            c_val = shifted[PW-1] ? SMIN : SMAX;
        sum_wide = {acc_cur[W_REWARD-1], acc_cur} + {c_val[W_REWARD-1], c_val};
        if (sum_wide[W_REWARD] != sum_wide[W_REWARD-1])
            exp_sum = sum_wide[W_REWARD] ? SMIN : SMAX;
        else
            exp_sum = sum_wide[W_REWARD-1:0];
    end
`else
    assign c_val   = W_REWARD'(prod >>> W_FRAC);
    assign exp_sum = acc_cur + c_val;
`endif

    // Merge the contribution into the parent according to its strategy.
    always_comb begin
        acc_new   = c_val;
        bestc_new = c_val;
        best_take = 1'b1;
        if (has_child_q[p_i]) begin
            case (strat_mem[p_i])
                2'b00: begin
                    best_take = (c_val < acc_cur);
                    acc_new   = best_take ? c_val : acc_cur;
                    bestc_new = bestc_cur;
                end
                2'b10: begin
                    acc_new   = exp_sum;
                    best_take = (c_val > bestc_cur);
                    bestc_new = best_take ? c_val : bestc_cur;
                end
                default: begin
                    best_take = (c_val > acc_cur);
                    acc_new   = best_take ? c_val : acc_cur;
                    bestc_new = bestc_cur;
                end
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        nodes_d      = nodes_q;
        has_child_d  = has_child_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        chg_d        = chg_q;
        exp_change_d = 1'b0;
        exp_d        = exp_q;
        act_d        = act_q;
        node_wr      = 1'b0;
        case (state_q)
            S_IDLE: begin
                nodes_d = nodes_eff;
                if (start) begin
                    has_child_d = '0;
                    idx_d       = W_ADDR'(nodes_eff) - W_ADDR'(1);
                    busy_d      = 1'b1;
                    state_d     = (nodes_eff == NW'(1)) ? S_FINAL : S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (bad) begin
                    err_d   = 1'b1;
                    chg_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    node_wr          = 1'b1;
                    has_child_d[p_i] = 1'b1;
                    if (idx_q == W_ADDR'(1))
                        state_d = S_FINAL;
                    else
                        idx_d = idx_q - W_ADDR'(1);
                end
            end
            S_FINAL: begin
                if (has_child_q[0]) begin
                    exp_d = acc_mem[0];
                    act_d = action_mem[best_mem[0]];
                end else begin
                    exp_d = reward_mem[0];
                    act_d = '0;
                end
                chg_d   = (exp_d != exp_q);
                err_d   = 1'b0;
                state_d = S_DONE;
            end
            default: begin
                done_d       = 1'b1;
                exp_change_d = chg_q;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (node_wr) begin
            acc_mem[p_i]   <= acc_new;
            bestc_mem[p_i] <= bestc_new;
            if (best_take) best_mem[p_i] <= idx_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            nodes_q      <= NW'(1);
            has_child_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            chg_q        <= 1'b0;
            exp_change_q <= 1'b0;
            exp_q        <= '0;
            act_q        <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            nodes_q      <= nodes_d;
            has_child_q  <= has_child_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            chg_q        <= chg_d;
            exp_change_q <= exp_change_d;
            exp_q        <= exp_d;
            act_q        <= act_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign exp_change = exp_change_q;
    assign exp        = exp_q;
    assign act        = act_q;
endmodule

// File: tb/tb_treeval_mx.sv
// Bench for treeval_mx: directed scenarios then randomized trees checked against a per-node reference model.
module tb_treeval_mx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mem_weight = 0, mem_par = 0, mem_rew = 0, mem_act = 0;
    logic [9:0] mem_addr = '0, mem_data = '0;
    logic       conf_nodes = 0;
    logic [9:0] conf_data = '0;
    logic       start = 0;
    logic       busy, done, err, exp_change;
    logic [9:0] exp_o;
    logic [2:0] act_o;

    treeval_mx dut (
        .clk(clk), .rst(rst),
        .mem_weight(mem_weight), .mem_par(mem_par), .mem_rew(mem_rew), .mem_act(mem_act),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .conf_nodes(conf_nodes), .conf_data(conf_data), .start(start),
        .busy(busy), .done(done), .err(err), .exp_change(exp_change),
        .exp(exp_o), .act(act_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int par[16], rew[16], wt[16], actn[16], strt[16];
    int prev_exp = 0;
    int prev_act = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int narrow(input int x);
        int y;
`ifdef TREEVAL_SAT_EN
        if (x > 511) return 511;
        if (x < -512) return -512;
        return x;
`else
        y = x & 1023;
        if (y >= 512) y -= 1024;
        return y;
`endif
    endfunction

    function automatic int clamp_nodes(input int c);
        if (c == 0) return 1;
        if (c > 16) return 16;
        return c;
    endfunction

    // Reference: each node gathers its children (highest index first) and combines their contributions.
    task automatic model(input int nn, output int e_exp, output int e_act, output int e_err,
                         output int e_chg, output int e_lat);
        int val[16], cv[16], bestk[16];
        bit hk[16];
        int bad, a, bc, b, c;
        bit any;
        bad = -1;
        for (int k = nn - 1; k >= 1; k--)
            if (par[k] >= k && bad < 0) bad = k;
        if (bad >= 0) begin
            e_err = 1; e_exp = prev_exp; e_act = prev_act; e_chg = 0; e_lat = nn - bad + 1;
            return;
        end
        for (int n = nn - 1; n >= 0; n--) begin
            any = 0; a = 0; bc = 0; b = 0;
            for (int k = nn - 1; k > n; k--) begin
                if (par[k] == n) begin
                    c = cv[k];
                    if (!any) begin
                        any = 1; a = c; bc = c; b = k;
                    end else begin
                        case (strt[n])
                            0: if (c < a) begin a = c; b = k; end
                            2: begin a = narrow(a + c); if (c > bc) begin bc = c; b = k; end end
                            default: if (c > a) begin a = c; b = k; end
                        endcase
                    end
                end
            end
            val[n]   = any ? a : rew[n];
            hk[n]    = any;
            bestk[n] = b;
            cv[n]    = narrow((wt[n] * val[n]) >>> 7);
        end
        e_err = 0;
        e_exp = val[0];
        e_act = hk[0] ? actn[bestk[0]] : 0;
        e_chg = (e_exp != prev_exp) ? 1 : 0;
        e_lat = (nn == 1) ? 2 : nn + 1;
        prev_exp = e_exp;
        prev_act = e_act;
    endtask

    task automatic wr(input int sel, input int addr, input int data);
        @(negedge clk);
        mem_addr = 10'(addr);
        mem_data = 10'(data);
        mem_weight = (sel == 0); mem_par = (sel == 1); mem_rew = (sel == 2); mem_act = (sel == 3);
        @(negedge clk);
        mem_weight = 0; mem_par = 0; mem_rew = 0; mem_act = 0;
    endtask

    task automatic set_node(input int n, input int p, input int r, input int w, input int a, input int s);
        wr(1, n, p); wr(2, n, r); wr(0, n, w); wr(3, n, (s << 3) | a);
        par[n] = p; rew[n] = r; wt[n] = w; actn[n] = a; strt[n] = s;
    endtask

    task automatic run_eval(input string tag, input int conf_val, input int poke,
                            input int e_lat, input int e_exp, input int e_act,
                            input int e_err, input int e_chg);
        int lat;
        bit seen;
        lat = -1; seen = 0;
        @(negedge clk);
        start = 1;
        if (conf_val >= 0) begin conf_nodes = 1; conf_data = 10'(conf_val); end
        @(posedge clk); #1;
        start = 0; conf_nodes = 0;
        check({tag, "_busy_hi"}, busy, 1);
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(posedge clk); #1;
            start = 0; mem_rew = 0;
            if (done) begin seen = 1; lat = i; end
            if (poke != 0 && i == 2) begin
                start = 1; mem_rew = 1; mem_addr = 10'd3; mem_data = 10'd200;
            end
        end
        check({tag, "_latency"}, lat, e_lat);
        check({tag, "_exp"}, $signed(exp_o), e_exp);
        check({tag, "_act"}, act_o, e_act);
        check({tag, "_err"}, err, e_err);
        check({tag, "_exp_change"}, exp_change, e_chg);
        check({tag, "_busy_lo"}, busy, 0);
        $display("eval %s: lat=%0d exp=%0d act=%0d err=%0b chg=%0b", tag, lat, $signed(exp_o), act_o, err, exp_change);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 0);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        int e_exp, e_act, e_err, e_chg, e_lat, cnt, nn, cv, bad_k;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_exp_change", exp_change, 0);
        check("rst_exp", $signed(exp_o), 0);
        check("rst_act", act_o, 0);
        @(negedge clk); rst = 1;

        for (int n = 0; n < 16; n++) set_node(n, 0, 0, 0, 0, 1);
        set_node(1, 0, 0, 64, 1, 1);
        set_node(2, 0, -10, 64, 1, 1);
        set_node(3, 0, 0, 128, 0, 1);
        set_node(4, 1, 100, 64, 1, 1);
        set_node(5, 1, -50, 64, 1, 1);
        set_node(6, 1, 10, 128, 0, 1);

        model(7, e_exp, e_act, e_err, e_chg, e_lat);
        run_eval("all_max", 7, 0, 8, 25, 1, 0, 1);
        set_node(0, 0, 0, 0, 0, 0);
        model(7, e_exp, e_act, e_err, e_chg, e_lat);
        run_eval("root_min", -1, 0, 8, -5, 1, 0, 1);
        set_node(0, 0, 0, 0, 0, 2);
        model(7, e_exp, e_act, e_err, e_chg, e_lat);
        run_eval("root_exp", -1, 0, 8, 20, 1, 0, 1);
        model(7, e_exp, e_act, e_err, e_chg, e_lat);
        run_eval("rerun_poke", -1, 1, 8, 20, 1, 0, 0);
        count_dones(15, cnt);
        check("no_extra_done", cnt, 0);

        set_node(1, 0, 511, 128, 1, 1);
        set_node(2, 0, 511, 128, 1, 1);
        model(3, e_exp, e_act, e_err, e_chg, e_lat);
`ifdef TREEVAL_SAT_EN
        run_eval("exp_overflow", 3, 0, 4, 511, 1, 0, 1);
`else
        run_eval("exp_overflow", 3, 0, 4, -2, 1, 0, 1);
`endif
        set_node(3, 5, 0, 128, 0, 1);
        model(7, e_exp, e_act, e_err, e_chg, e_lat);
        run_eval("bad_tree", 7, 0, 5, e_exp, 1, 1, 0);
        set_node(3, 0, 0, 128, 0, 1);
        model(7, e_exp, e_act, e_err, e_chg, e_lat);
        run_eval("bad_recover", -1, 0, e_lat, e_exp, e_act, 0, e_chg);

        @(negedge clk); start = 1;
        @(posedge clk); #1; start = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        check("midrst_busy", busy, 0);
        check("midrst_exp", $signed(exp_o), 0);
        check("midrst_act", act_o, 0);
        check("midrst_done", done, 0);
        @(negedge clk); rst = 1;
        count_dones(20, cnt);
        check("midrst_no_done", cnt, 0);
        prev_exp = 0; prev_act = 0;

        set_node(0, 0, -7, 0, 0, 2);
        model(1, e_exp, e_act, e_err, e_chg, e_lat);
        run_eval("single_node", 0, 0, 2, -7, 0, 0, 1);
        wr(2, 16, 100);
        model(1, e_exp, e_act, e_err, e_chg, e_lat);
        run_eval("oob_write", -1, 0, 2, -7, 0, 0, 0);

        for (int t = 0; t < 24; t++) begin
            cv = $urandom_range(0, 20);
            nn = clamp_nodes(cv);
            for (int n = 0; n < 16; n++)
                set_node(n, (n == 0) ? 0 : $urandom_range(0, n - 1), $urandom_range(0, 1023) - 512,
                         $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) begin
                bad_k = $urandom_range(1, 15);
                set_node(bad_k, $urandom_range(bad_k, 15), rew[bad_k], wt[bad_k], actn[bad_k], strt[bad_k]);
            end
            model(nn, e_exp, e_act, e_err, e_chg, e_lat);
            run_eval($sformatf("rand%0d", t), cv, 0, e_lat, e_exp, e_act, e_err, e_chg);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
